// File: rtl/exe_mem_pipe_reg_pkg.sv
// Shared EXE->MEM payload layout and FSM encoding.
// Payload field order, MSB first: {wb_en, mem_r_en, mem_w_en, alu_result, st_val, dest}.
package arm_pipe_pkg;

  localparam int BIT_NUMBER_DEF = 32;
  localparam int DEST_W_DEF     = 4;

  function automatic int payload_w(input int bit_number, input int dest_w);
    return 3 + 2 * bit_number + dest_w;
  endfunction

  localparam int EXE_MEM_PAYLOAD_W = payload_w(BIT_NUMBER_DEF, DEST_W_DEF);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/exe_mem_pipe_reg_if.sv
// EXE->MEM handshake bundle; slave is the pipeline register, master is the surrounding logic.
// Forwarding taps exist only when EXE_MEM_FWD_EN is defined.
interface exe_mem_pipe_reg_if #(
  parameter int BIT_NUMBER = 32,
  parameter int DEST_W     = 4
) ();
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic                  wb_en_in;
  logic                  mem_r_en_in;
  logic                  mem_w_en_in;
  logic [BIT_NUMBER-1:0] alu_result_in;
  logic [BIT_NUMBER-1:0] st_val_in;
  logic [DEST_W-1:0]     dest_in;
  logic                  out_valid;
  logic                  out_ready;
  logic                  wb_en;
  logic                  mem_r_en;
  logic                  mem_w_en;
  logic [BIT_NUMBER-1:0] alu_result;
  logic [BIT_NUMBER-1:0] st_val;
  logic [DEST_W-1:0]     dest;
`ifdef EXE_MEM_FWD_EN
  logic                  fwd_valid;
  logic [DEST_W-1:0]     fwd_dest;
  logic [BIT_NUMBER-1:0] fwd_value;
  logic                  fwd_skid_valid;
  logic [DEST_W-1:0]     fwd_skid_dest;
  logic [BIT_NUMBER-1:0] fwd_skid_value;
`endif

  modport slave (
    input  flush, in_valid, wb_en_in, mem_r_en_in, mem_w_en_in,
           alu_result_in, st_val_in, dest_in, out_ready,
`ifdef EXE_MEM_FWD_EN
    output fwd_valid, fwd_dest, fwd_value,
           fwd_skid_valid, fwd_skid_dest, fwd_skid_value,
`endif
    output in_ready, out_valid, wb_en, mem_r_en, mem_w_en,
           alu_result, st_val, dest
  );

  modport master (
    output flush, in_valid, wb_en_in, mem_r_en_in, mem_w_en_in,
           alu_result_in, st_val_in, dest_in, out_ready,
`ifdef EXE_MEM_FWD_EN
    input  fwd_valid, fwd_dest, fwd_value,
           fwd_skid_valid, fwd_skid_dest, fwd_skid_value,
`endif
    input  in_ready, out_valid, wb_en, mem_r_en, mem_w_en,
           alu_result, st_val, dest
  );

endinterface

// File: rtl/exe_mem_pipe_reg_pipe_slot.sv
// One payload register with a valid flag; clear wins over load.
module pipe_slot #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM pipeline register: ready/valid handshake, 2-entry skid buffer, synchronous flush.
// Define EXE_MEM_FWD_EN to add forwarding taps on the head and skid entries.
module exe_mem_pipe_reg
  import arm_pipe_pkg::*;
#(
  parameter int BIT_NUMBER = BIT_NUMBER_DEF,
  parameter int DEST_W     = DEST_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  exe_mem_pipe_reg_if.slave  bus
);

  localparam int PW = payload_w(BIT_NUMBER, DEST_W);

  state_t          state_q, state_next;
  logic            armed_q;
  logic            accept, take;
  logic            main_load, main_clear, main_sel_skid;
  logic            skid_load, skid_clear;
  logic            main_valid, skid_valid;
  logic [PW-1:0]   in_payload, main_d, main_q, skid_q;

  logic                  m_wb, m_mr, m_mw;
  logic [BIT_NUMBER-1:0] m_alu, m_st;
  logic [DEST_W-1:0]     m_dest;

  assign in_payload = {bus.wb_en_in, bus.mem_r_en_in, bus.mem_w_en_in,
                       bus.alu_result_in, bus.st_val_in, bus.dest_in};

  // in_ready comes straight from flops: it drops on the same edge the skid fills,
  // and stays low during reset until the first edge after release.
  assign bus.in_ready = armed_q & ~skid_valid;
  assign accept       = bus.in_valid & bus.in_ready;
  assign take         = main_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_next;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_next    = state_q;
    main_load     = 1'b0;
    main_clear    = 1'b0;
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    if (bus.flush) begin
      state_next = ST_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_next = ST_ONE;
            main_load  = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && take) begin
            main_load = 1'b1;
          end else if (accept) begin
            state_next = ST_TWO;
            skid_load  = 1'b1;
          end else if (take) begin
            state_next = ST_EMPTY;
            main_clear = 1'b1;
          end
        end
        ST_TWO: begin
          if (take) begin
            state_next    = ST_ONE;
            main_load     = 1'b1;
            main_sel_skid = 1'b1;
            skid_clear    = 1'b1;
          end
        end
        default: begin
          state_next = ST_EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign main_d = main_sel_skid ? skid_q : in_payload;

  pipe_slot #(.W(PW)) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_q)
  );

  pipe_slot #(.W(PW)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (in_payload),
    .valid (skid_valid),
    .q     (skid_q)
  );

  assign {m_wb, m_mr, m_mw, m_alu, m_st, m_dest} = main_q;

  // Enables are gated so a bubble or flushed entry can never write.
  assign bus.out_valid  = main_valid;
  assign bus.wb_en      = m_wb & main_valid;
  assign bus.mem_r_en   = m_mr & main_valid;
  assign bus.mem_w_en   = m_mw & main_valid;
  assign bus.alu_result = m_alu;
  assign bus.st_val     = m_st;
  assign bus.dest       = m_dest;

`ifdef EXE_MEM_FWD_EN
  logic                  s_wb, s_mr, s_mw;
  logic [BIT_NUMBER-1:0] s_alu, s_st;
  logic [DEST_W-1:0]     s_dest;

  assign {s_wb, s_mr, s_mw, s_alu, s_st, s_dest} = skid_q;

  // Loads are excluded: their result is not known until MEM completes.
  assign bus.fwd_valid      = main_valid & m_wb & ~m_mr;
  assign bus.fwd_dest       = m_dest;
  assign bus.fwd_value      = m_alu;
  assign bus.fwd_skid_valid = skid_valid & s_wb & ~s_mr;
  assign bus.fwd_skid_dest  = s_dest;
  assign bus.fwd_skid_value = s_alu;

  logic unused_skid;
  assign unused_skid = ^{s_mw, s_st};
`endif

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Directed bench for exe_mem_pipe_reg: reset, streaming, stall/skid, flush, bubble gating,
// async reset mid-operation, and forwarding taps when EXE_MEM_FWD_EN is defined.
module tb_exe_mem_pipe_reg;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  exe_mem_pipe_reg_if #(.BIT_NUMBER(32), .DEST_W(4)) bus ();

  exe_mem_pipe_reg #(.BIT_NUMBER(32), .DEST_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic wb, input logic mr, input logic mw,
                       input logic [31:0] alu, input logic [31:0] st, input logic [3:0] d);
    bus.in_valid      = v;
    bus.wb_en_in      = wb;
    bus.mem_r_en_in   = mr;
    bus.mem_w_en_in   = mw;
    bus.alu_result_in = alu;
    bus.st_val_in     = st;
    bus.dest_in       = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] alu, input logic [31:0] st,
                          input logic [3:0] d);
    chk({tag, ".valid"}, {63'd0, bus.out_valid}, 64'd1);
    chk({tag, ".alu"},   {32'd0, bus.alu_result}, {32'd0, alu});
    chk({tag, ".st"},    {32'd0, bus.st_val}, {32'd0, st});
    chk({tag, ".dest"},  {60'd0, bus.dest}, {60'd0, d});
  endtask

  initial begin
    // Reset with random inputs
    rst       = 1'b1;
    bus.flush = 1'($urandom);
    bus.out_ready = 1'($urandom);
    drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, 4'($urandom));
    #12;
    chk("rst.out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst.in_ready",  {63'd0, bus.in_ready}, 64'd0);
    chk("rst.enables",   {61'd0, bus.wb_en, bus.mem_r_en, bus.mem_w_en}, 64'd0);
    chk("rst.alu",       {32'd0, bus.alu_result}, 64'd0);
    chk("rst.st",        {32'd0, bus.st_val}, 64'd0);
    chk("rst.dest",      {60'd0, bus.dest}, 64'd0);
    idle();
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk("rel.in_ready",  {63'd0, bus.in_ready}, 64'd1);
    chk("rel.out_valid", {63'd0, bus.out_valid}, 64'd0);

    // Streaming at full throughput
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'(i), 32'h10 + 32'(i), 32'h100 + 32'(i), 4'(i + 1));
      step();
      chk_head($sformatf("stream%0d", i), 32'h10 + 32'(i), 32'h100 + 32'(i), 4'(i + 1));
      chk($sformatf("stream%0d.mem_w", i), {63'd0, bus.mem_w_en}, {63'd0, 1'(i)});
      chk($sformatf("stream%0d.wb", i), {63'd0, bus.wb_en}, 64'd1);
      chk($sformatf("stream%0d.in_ready", i), {63'd0, bus.in_ready}, 64'd1);
    end
    idle();
    step();
    chk("stream.drain", {63'd0, bus.out_valid}, 64'd0);

    // Stall: two accepted, third refused, then drained in order
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hA0, 32'hB0, 4'h3);
    step();
    chk_head("stall.a0", 32'hA0, 32'hB0, 4'h3);
    chk("stall.rdy1", {63'd0, bus.in_ready}, 64'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hA1, 32'hB1, 4'h4);
    step();
    chk_head("stall.hold1", 32'hA0, 32'hB0, 4'h3);
    chk("stall.rdy2", {63'd0, bus.in_ready}, 64'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hA2, 32'hB2, 4'h5);
    step();
    chk_head("stall.hold2", 32'hA0, 32'hB0, 4'h3);
    chk("stall.rdy3", {63'd0, bus.in_ready}, 64'd0);
    step();
    chk_head("stall.hold3", 32'hA0, 32'hB0, 4'h3);
    bus.out_ready = 1'b1;
    step();
    chk_head("stall.a1", 32'hA1, 32'hB1, 4'h4);
    chk("stall.rdy4", {63'd0, bus.in_ready}, 64'd1);
    step();
    chk_head("stall.a2", 32'hA2, 32'hB2, 4'h5);
    chk("stall.a2.mem_w", {63'd0, bus.mem_w_en}, 64'd1);
    idle();
    step();
    chk("stall.drain", {63'd0, bus.out_valid}, 64'd0);

    // Flush while TWO, with a concurrent input
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hC0, 32'hD0, 4'h6);
    step();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hC1, 32'hD1, 4'h7);
    step();
    chk("flush2.pre_rdy", {63'd0, bus.in_ready}, 64'd0);
    bus.flush = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hC2, 32'hD2, 4'h8);
    step();
    bus.flush = 1'b0;
    chk("flush2.valid",   {63'd0, bus.out_valid}, 64'd0);
    chk("flush2.enables", {61'd0, bus.wb_en, bus.mem_r_en, bus.mem_w_en}, 64'd0);
    chk("flush2.rdy",     {63'd0, bus.in_ready}, 64'd1);
    idle();
    step();
    chk("flush2.nocap", {63'd0, bus.out_valid}, 64'd0);

    // Flush in ONE overrides a concurrent accept
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hE0, 32'hF0, 4'h9);
    step();
    chk_head("flush1.pre", 32'hE0, 32'hF0, 4'h9);
    bus.flush = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hE1, 32'hF1, 4'hA);
    step();
    bus.flush = 1'b0;
    idle();
    chk("flush1.valid", {63'd0, bus.out_valid}, 64'd0);
    chk("flush1.wb",    {63'd0, bus.wb_en}, 64'd0);
    step();
    chk("flush1.nocap", {63'd0, bus.out_valid}, 64'd0);

    // Bubble gating
    bus.out_ready = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h55, 32'h66, 4'hB);
    step();
    chk("bubble.valid", {63'd0, bus.out_valid}, 64'd0);
    chk("bubble.wb",    {63'd0, bus.wb_en}, 64'd0);
    chk("bubble.mem_w", {63'd0, bus.mem_w_en}, 64'd0);

    // Async reset mid-operation
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h77, 32'h88, 4'hC);
    step();
    chk_head("arst.pre", 32'h77, 32'h88, 4'hC);
    #1 rst = 1'b1;
    #1;
    chk("arst.valid",   {63'd0, bus.out_valid}, 64'd0);
    chk("arst.enables", {61'd0, bus.wb_en, bus.mem_r_en, bus.mem_w_en}, 64'd0);
    chk("arst.alu",     {32'd0, bus.alu_result}, 64'd0);
    chk("arst.rdy",     {63'd0, bus.in_ready}, 64'd0);
    idle();
    #1 rst = 1'b0;
    step();
    chk("arst.rel_rdy",   {63'd0, bus.in_ready}, 64'd1);
    chk("arst.rel_valid", {63'd0, bus.out_valid}, 64'd0);

`ifdef EXE_MEM_FWD_EN
    // Forwarding taps
    bus.out_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h4321, 32'h0, 4'h5);
    step();
    chk("fwd.load.valid", {63'd0, bus.out_valid}, 64'd1);
    chk("fwd.load.fwd",   {63'd0, bus.fwd_valid}, 64'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 4'h5);
    step();
    chk("fwd.alu.valid", {63'd0, bus.fwd_valid}, 64'd1);
    chk("fwd.alu.dest",  {60'd0, bus.fwd_dest}, 64'd5);
    chk("fwd.alu.value", {32'd0, bus.fwd_value}, 64'h1234);
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 4'h7);
    step();
    chk("fwd.skid.valid", {63'd0, bus.fwd_skid_valid}, 64'd1);
    chk("fwd.skid.dest",  {60'd0, bus.fwd_skid_dest}, 64'd7);
    chk("fwd.skid.value", {32'd0, bus.fwd_skid_value}, 64'h77);
    bus.flush = 1'b1;
    idle();
    step();
    bus.flush = 1'b0;
    chk("fwd.flush.head", {27'd0, bus.fwd_valid, bus.fwd_dest, bus.fwd_value}, 64'd0);
    chk("fwd.flush.skid", {27'd0, bus.fwd_skid_valid, bus.fwd_skid_dest, bus.fwd_skid_value}, 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
